dvi_fb_arbiter: RTL and testbench

Arbitrates one single-port, synchronous-read pixel memory between two users. The display side requests a line prefetch during horizontal blanking, and the block streams LINE_WORDS consecutive words into a line buffer. The host side writes pixel words through a valid/ready port. The block sits in the pixel_clk_i domain, between the frame memory and the line buffer that feeds the pixel-generation logic ahead of the TMDS encoders.

---
 rtl/dvi_fb_arbiter.sv | 146 ++++++++++++++
 tb/tb_dvi_fb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dvi_fb_arbiter: shares a sync-read frame memory between line prefetch and  |
// | host writes. Optional macro ARB_WR_SLOT_EN opens host write slots in FETCH.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dvi_fb_arbiter #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 8,
  parameter int LINE_WORDS     = 80,
  parameter int LB_ADDR_W      = 7,
  parameter int WR_SLOT_PERIOD = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fetch_req_i,
  input  logic [ADDR_W-1:0]    fetch_base_i,
  output logic                 fetch_done_o,
  output logic                 busy_o,
  output logic                 fetch_overrun_o,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  output logic                 lb_we_o,
  output logic [LB_ADDR_W-1:0] lb_addr_o,
  output logic [DATA_W-1:0]    lb_data_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [LB_ADDR_W-1:0] c_last_cnt = LB_ADDR_W'(LINE_WORDS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_base;
  logic [LB_ADDR_W-1:0] r_cnt;
  logic [LB_ADDR_W-1:0] r_lb_addr;
  logic                 r_lb_vld;
  logic                 r_overrun;
  logic                 w_wr_slot;
  logic                 w_rd_issue;
  logic                 w_wr_issue;
  logic                 w_last_rd;

`ifdef ARB_WR_SLOT_EN
  localparam int SLOT_W = (WR_SLOT_PERIOD > 1) ? $clog2(WR_SLOT_PERIOD) : 1;
  localparam logic [SLOT_W-1:0] c_slot_last = SLOT_W'(WR_SLOT_PERIOD - 1);

  logic [SLOT_W-1:0] r_slot_cnt;

  // Counts cycles spent in FETCH; the last phase of each period is a write slot.
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != ST_FETCH) begin
      r_slot_cnt <= '0;
    end else if (r_slot_cnt == c_slot_last) begin
      r_slot_cnt <= '0;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  assign w_wr_slot  = (r_state == ST_FETCH) && (r_slot_cnt == c_slot_last) && wr_valid_i;
  assign wr_ready_o = !rst_i && (((r_state == ST_IDLE) && !fetch_req_i) ||
                                 (r_state == ST_DRAIN) || w_wr_slot);
`else
  logic w_unused_slot;
  assign w_unused_slot = (WR_SLOT_PERIOD > 0);
  assign w_wr_slot     = 1'b0;
  assign wr_ready_o    = !rst_i && (r_state == ST_IDLE) && !fetch_req_i;
`endif

  assign w_rd_issue = !rst_i && (r_state == ST_FETCH) && !w_wr_slot;
  assign w_wr_issue = wr_valid_i && wr_ready_o;
  assign w_last_rd  = w_rd_issue && (r_cnt == c_last_cnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_base    <= '0;
      r_cnt     <= '0;
      r_lb_addr <= '0;
      r_lb_vld  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lb_vld <= w_rd_issue;
      if (w_rd_issue) begin
        r_lb_addr <= r_cnt;
        r_cnt     <= r_cnt + 1'b1;
      end
      if ((r_state == ST_IDLE) && fetch_req_i) begin
        r_base <= fetch_base_i;
        r_cnt  <= '0;
      end
      if ((r_state != ST_IDLE) && fetch_req_i) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (fetch_req_i) w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_last_rd)   w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // A read and a host write never coincide: ready is withheld whenever a read issues.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_rd_issue) begin
      mem_en_o   = 1'b1;
      mem_addr_o = r_base + ADDR_W'(r_cnt);
    end else if (w_wr_issue) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = wr_addr_i;
      mem_wdata_o = wr_data_i;
    end
  end

  assign busy_o          = !rst_i && (r_state != ST_IDLE);
  assign fetch_done_o    = !rst_i && (r_state == ST_DRAIN);
  assign fetch_overrun_o = r_overrun;
  assign lb_we_o         = !rst_i && r_lb_vld;
  assign lb_addr_o       = r_lb_addr;
  assign lb_data_o       = mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_dvi_fb_arbiter.sv
`default_nettype none
// Directed bench for dvi_fb_arbiter with a synchronous-read memory model.
module tb_dvi_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [14:0] fetch_base = '0;
  logic        fetch_done, busy, fetch_overrun;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [14:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        lb_we;
  logic [6:0]  lb_addr;
  logic [7:0]  lb_data;

  int total = 0;
  int bad   = 0;

  dvi_fb_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .fetch_req_i(fetch_req), .fetch_base_i(fetch_base),
    .fetch_done_o(fetch_done), .busy_o(busy), .fetch_overrun_o(fetch_overrun),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .lb_we_o(lb_we), .lb_addr_o(lb_addr), .lb_data_o(lb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  logic [7:0] mem [0:32767];
  initial for (int i = 0; i < 32768; i++) mem[i] = pat(15'(i));

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-run observations
  int rd_n, lb_n, rd_err, lb_err, done_n, done_cyc, busy_n, rdy_busy, rdy0;
  int wr_n, wr_cyc, wr_err, slot_wr, first_rd, first_lb, timeout;
  int ovr_at_v, ovr_next, rst_busy, rst_lbwe;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", fetch_done, 0);
    check("rst_lbwe", lb_we, 0);
    check("rst_wrrdy", wr_ready, 0);
    @(negedge clk);
    check("rst_lbaddr", lb_addr, 0);
    check("rst_ovr", fetch_overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // host_mode: 0 none, 1 single write held until accepted, 2 continuous writes until done
  task automatic run_fetch(input logic [14:0] base, input int ovr_at, input int rst_at,
                           input int host_mode);
    int c;
    bit finished, host_done, done_seen, acc;
    logic [14:0] ea;
    rd_n = 0; lb_n = 0; rd_err = 0; lb_err = 0; done_n = 0; done_cyc = -1;
    busy_n = 0; rdy_busy = 0; rdy0 = -1; wr_n = 0; wr_cyc = -1; wr_err = 0;
    slot_wr = 0; first_rd = -1; first_lb = -1; timeout = 0;
    ovr_at_v = -1; ovr_next = -1; rst_busy = -1; rst_lbwe = -1;
    c = 0; finished = 0; host_done = 0; done_seen = 0;
    @(posedge clk); #1;
    fetch_req  = 1'b1;
    fetch_base = base;
    if (host_mode != 0) wr_valid = 1'b1;
    while (!finished) begin
      @(negedge clk);
      if (c == 0) rdy0 = int'(wr_ready);
      if (mem_en && !mem_we) begin
        ea = base + 15'(rd_n);
        if (mem_addr !== ea) rd_err++;
        if (first_rd < 0) first_rd = c;
        rd_n++;
      end
      if (lb_we) begin
        ea = base + 15'(lb_n);
        if (lb_addr !== 7'(lb_n) || lb_data !== pat(ea)) lb_err++;
        if (first_lb < 0) first_lb = c;
        lb_n++;
      end
      if (fetch_done) begin done_n++; done_cyc = c; done_seen = 1; end
      if (busy) busy_n++;
      if (busy && wr_ready) rdy_busy++;
      acc = wr_valid && wr_ready;
      if (mem_we) begin
        wr_n++;
        wr_cyc = c;
        if (mem_addr !== wr_addr || mem_wdata !== wr_data) wr_err++;
        if (busy && !fetch_done) slot_wr++;
      end
      if (acc && host_mode == 1) host_done = 1;
      if (c == ovr_at)     ovr_at_v = int'(fetch_overrun);
      if (c == ovr_at + 1) ovr_next = int'(fetch_overrun);
      if (rst_at >= 0 && c == rst_at + 1) begin
        rst_busy = int'(busy);
        rst_lbwe = int'(lb_we);
        finished = 1;
      end
      if (rst_at < 0 && c >= 2 && !busy && (host_mode != 1 || host_done)) finished = 1;
      if (c > 400) begin timeout = 1; finished = 1; end
      @(posedge clk); #1;
      c++;
      fetch_req = (c == ovr_at);
      if (c == ovr_at) fetch_base = ~base;
      rst = (c == rst_at);
      if (acc && host_mode == 1) wr_valid = 1'b0;
      if (acc && host_mode == 2) begin
        wr_addr = wr_addr + 15'd1;
        wr_data = wr_data + 8'd3;
      end
      if (host_mode == 2 && done_seen) wr_valid = 1'b0;
    end
    fetch_req = 1'b0;
    rst       = 1'b0;
    wr_valid  = 1'b0;
    check("timeout", timeout, 0);
  endtask

  initial begin
    do_reset();

    // Plain fetch
    run_fetch(15'h0100, -1, -1, 0);
    check("t1_rd_err", rd_err, 0);
    check("t1_rd_n", rd_n, 80);
    check("t1_first_rd", first_rd, 1);
    check("t1_lb_err", lb_err, 0);
    check("t1_lb_n", lb_n, 80);
    check("t1_first_lb", first_lb, 2);
    check("t1_done_n", done_n, 1);
    check("t1_done_cyc", done_cyc, 81);
    check("t1_busy_n", busy_n, 81);

    // Address wrap past the top of memory
    run_fetch(15'h7FD8, -1, -1, 0);
    check("t2_rd_err", rd_err, 0);
    check("t2_rd_n", rd_n, 80);
    check("t2_lb_err", lb_err, 0);
    check("t2_done_cyc", done_cyc, 81);

`ifndef ARB_WR_SLOT_EN
    // Host write collides with a fetch request
    wr_addr = 15'h2345;
    wr_data = 8'hA5;
    run_fetch(15'h0300, -1, -1, 1);
    check("t3_rdy0", rdy0, 0);
    check("t3_rdy_busy", rdy_busy, 0);
    check("t3_wr_n", wr_n, 1);
    check("t3_wr_cyc", wr_cyc, 82);
    check("t3_wr_err", wr_err, 0);
    check("t3_mem", mem[15'h2345], 8'hA5);
    check("t3_lb_err", lb_err, 0);
`endif

    // Second request mid-fetch
    run_fetch(15'h0400, 40, -1, 0);
    check("t4_ovr_at40", ovr_at_v, 0);
    check("t4_ovr_41", ovr_next, 1);
    check("t4_rd_err", rd_err, 0);
    check("t4_rd_n", rd_n, 80);
    check("t4_lb_err", lb_err, 0);
    check("t4_done_cyc", done_cyc, 81);
    repeat (3) @(posedge clk);
    #1;
    check("t4_ovr_sticky", fetch_overrun, 1);
    do_reset();

    // Reset mid-fetch, then a clean fetch
    run_fetch(15'h0500, -1, 30, 0);
    check("t5_busy", rst_busy, 0);
    check("t5_lbwe", rst_lbwe, 0);
    check("t5_done_n", done_n, 0);
    run_fetch(15'h0200, -1, -1, 0);
    check("t5b_lb_err", lb_err, 0);
    check("t5b_lb_n", lb_n, 80);
    check("t5b_first_lb", first_lb, 2);
    check("t5b_done_cyc", done_cyc, 81);

`ifdef ARB_WR_SLOT_EN
    // Continuous host writes steal every fourth fetch cycle
    wr_addr = 15'h5000;
    wr_data = 8'h11;
    run_fetch(15'h0100, -1, -1, 2);
    check("t6_rd_err", rd_err, 0);
    check("t6_rd_n", rd_n, 80);
    check("t6_lb_err", lb_err, 0);
    check("t6_lb_n", lb_n, 80);
    check("t6_slot_wr", slot_wr, 26);
    check("t6_wr_err", wr_err, 0);
    check("t6_done_cyc", done_cyc, 107);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
